nv_latch_rf: RTL

NV_LATCH_RF -- requirements
Module: nv_latch_rf

---
 rtl/nv_latch_rf_pkg.sv | 17 +
 rtl/nv_latch_rf_row.sv | 17 +
 rtl/nv_latch_rf.sv | 114 +++++++++++
 3 files changed

// File: rtl/nv_latch_rf_pkg.sv
// nv_latch_rf shared package: FSM encoding and clog2 helper.
// Imported by the latch register file top and its row sub-module.
package nv_latch_rf_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/nv_latch_rf_row.sv
// nv_latch_rf_row: one DW-bit level-sensitive storage row.
// Transparent only while the row is enabled and the clock is low.
module nv_latch_rf_row #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  // open during the low phase of the enabled cycle only
  always_latch begin
    if (en_i && !clk_i) q_o <= d_i;
  end

endmodule

// File: rtl/nv_latch_rf.sv
// nv_latch_rf: latch-array register file with post-reset clear sweep.
// Optional same-cycle write-to-read bypass: NV_LATCH_RF_BYPASS_EN.
module nv_latch_rf
  import nv_latch_rf_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] di,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] dout,
  output logic          init_busy
);

  localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          stg_v_q, stg_v_d;
  logic [AW-1:0] stg_a_q, stg_a_d;
  logic [DW-1:0] stg_d_q, stg_d_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] rows [DEPTH];
  logic [DW-1:0] rd_data;
  logic [DW-1:0] rd_val;
  logic          wa_ok;

  assign wa_ok = ({1'b0, wa} < DEPTH_X);

  // read mux; addresses with no row fall through to zero
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ra == AW'(i)) rd_data = rows[i];
    end
  end

`ifdef NV_LATCH_RF_BYPASS_EN
  logic byp;
  assign byp    = we & wa_ok & (wa == ra);
  assign rd_val = byp ? di : rd_data;
`else
  assign rd_val = rd_data;
`endif

  // next state: clear sweep in INIT, staged writes and reads in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stg_v_d = 1'b0;
    stg_a_d = stg_a_q;
    stg_d_d = stg_d_q;
    dout_d  = dout_q;
    unique case (state_q)
      INIT: begin
        stg_v_d = 1'b1;
        stg_a_d = cnt_q;
        stg_d_d = '0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        stg_v_d = we & wa_ok;
        if (we) begin
          stg_a_d = wa;
          stg_d_d = di;
        end
        if (re) dout_d = rd_val;
      end
    endcase
  end

  // state, sweep counter, write staging and read data registers
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= INIT;
      cnt_q   <= '0;
      stg_v_q <= 1'b0;
      stg_a_q <= '0;
      stg_d_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stg_v_q <= stg_v_d;
      stg_a_q <= stg_a_d;
      stg_d_q <= stg_d_d;
      dout_q  <= dout_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    nv_latch_rf_row #(.DW(DW)) u_row (
      .clk_i (nvdla_core_clk),
      .en_i  (stg_v_q && (stg_a_q == AW'(i))),
      .d_i   (stg_d_q),
      .q_o   (rows[i])
    );
  end

  assign dout      = dout_q;
  assign init_busy = (state_q == INIT) & nvdla_core_rstn;

endmodule
